// File: rtl/zaxxon_rom_pkg.sv
// zaxxon_rom_pkg
// Shared definitions for the zaxxon ROM loader: the memory-region table for
// the concatenated ROM image, the region and loader-state enumerations, and
// lookup helpers so the region map lives in exactly one place.
// No ports (package).
package zaxxon_rom_pkg;

  // Bit position of each region in the one-hot rom_we strobe.
  typedef enum logic [2:0] {
    RGN_CPU,
    RGN_CHAR,
    RGN_BG,
    RGN_SPR,
    RGN_MAP,
    RGN_PROM
  } region_e;

  localparam int NUM_REGIONS = 6;

  localparam logic [24:0] CPU_BASE  = 25'h00000;
  localparam logic [24:0] CPU_SIZE  = 25'h06000;
  localparam logic [24:0] CHAR_BASE = 25'h06000;
  localparam logic [24:0] CHAR_SIZE = 25'h01000;
  localparam logic [24:0] BG_BASE   = 25'h07000;
  localparam logic [24:0] BG_SIZE   = 25'h06000;
  localparam logic [24:0] SPR_BASE  = 25'h0D000;
  localparam logic [24:0] SPR_SIZE  = 25'h06000;
  localparam logic [24:0] MAP_BASE  = 25'h13000;
  localparam logic [24:0] MAP_SIZE  = 25'h08000;
  localparam logic [24:0] PROM_BASE = 25'h1B000;
  localparam logic [24:0] PROM_SIZE = 25'h00200;

  // End of the region map; the loader's expected image length must match.
  localparam logic [24:0] ROM_TOTAL = PROM_BASE + PROM_SIZE;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } state_e;

  function automatic logic [24:0] region_base(input region_e r);
    case (r)
      RGN_CPU:  return CPU_BASE;
      RGN_CHAR: return CHAR_BASE;
      RGN_BG:   return BG_BASE;
      RGN_SPR:  return SPR_BASE;
      RGN_MAP:  return MAP_BASE;
      RGN_PROM: return PROM_BASE;
      default:  return 25'h0;
    endcase
  endfunction

  function automatic logic [24:0] region_size(input region_e r);
    case (r)
      RGN_CPU:  return CPU_SIZE;
      RGN_CHAR: return CHAR_SIZE;
      RGN_BG:   return BG_SIZE;
      RGN_SPR:  return SPR_SIZE;
      RGN_MAP:  return MAP_SIZE;
      RGN_PROM: return PROM_SIZE;
      default:  return 25'h0;
    endcase
  endfunction

endpackage

// File: rtl/zaxxon_rom_region_dec.sv
// zaxxon_rom_region_dec
// Purely combinational decode of a byte address in the concatenated ROM image
// into the region it belongs to and the address local to that region.
// Ports:
//   addr       in  25  byte address within the image
//   region_oh  out 6   one-hot region (bit order follows region_e)
//   local_addr out 16  addr minus the region base
//   in_range   out 1   addr falls inside some region of the map
module zaxxon_rom_region_dec
  import zaxxon_rom_pkg::*;
(
  input  logic [24:0] addr,
  output logic [5:0]  region_oh,
  output logic [15:0] local_addr,
  output logic        in_range
);

  // Regions are disjoint, so at most one iteration matches.
  always_comb begin
    logic [24:0] base;
    logic [24:0] limit;
    region_oh  = '0;
    local_addr = '0;
    in_range   = 1'b0;
    base       = '0;
    limit      = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      base  = region_base(region_e'(3'(i)));
      limit = base + region_size(region_e'(3'(i)));
      if (addr >= base && addr < limit) begin
        region_oh[i] = 1'b1;
        local_addr   = 16'(addr - base);
        in_range     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zaxxon_rom_loader.sv
// zaxxon_rom_loader
// Accepts the HPS ioctl download of the single concatenated zaxxon ROM image,
// splits it into per-region write strobes, and keeps the game core in reset
// until a complete, in-order, correctly sized image has been written.
// Ports:
//   clk_sys        in  1   system clock
//   reset          in  1   synchronous, active-high
//   ioctl_download in  1   download window active
//   ioctl_index    in  8   download target; only LOAD_INDEX is used
//   ioctl_wr       in  1   one-cycle byte strobe
//   ioctl_addr     in  25  byte address within the image
//   ioctl_dout     in  8   byte data
//   rom_we         out 6   one-hot region strobe {prom,map,spr,bg,char,cpu}
//   rom_addr       out 16  region-local address
//   rom_data       out 8   write data
//   core_hold      out 1   1 while no valid image is loaded
//   load_done      out 1   last image valid
//   load_error     out 1   last image invalid
//   byte_count     out 17  bytes accepted in the current or last load
//   checksum       out 16  sum of accepted bytes, mod 2^16
module zaxxon_rom_loader
  import zaxxon_rom_pkg::*;
#(
  parameter int unsigned TOTAL_BYTES = 32'h1B200,
  parameter logic [7:0]  LOAD_INDEX  = 8'd0
)(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [5:0]  rom_we,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [16:0] byte_count,
  output logic [15:0] checksum
);

  state_e      state;
  state_e      state_next;
  logic        act;
  logic        act_q;
  logic        act_rise;
  logic        act_fall;
  logic        start_load;
  logic        take_byte;
  logic        ovf;
  logic        ooo;
  logic        addr_ovf;
  logic [5:0]  dec_region;
  logic [15:0] dec_local;
  logic        dec_in_range;

  zaxxon_rom_region_dec u_dec (
    .addr       (ioctl_addr),
    .region_oh  (dec_region),
    .local_addr (dec_local),
    .in_range   (dec_in_range)
  );

  assign act      = ioctl_download && (ioctl_index == LOAD_INDEX);
  assign act_rise = act && !act_q;
  assign act_fall = !act && act_q;
  assign addr_ovf = !dec_in_range || (ioctl_addr >= 25'(TOTAL_BYTES));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A byte arriving on the same cycle that the download drops is still
  // taken, since take_byte does not depend on act while in LOAD.
  always_comb begin
    state_next = state;
    start_load = 1'b0;
    take_byte  = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (act_rise) begin
          state_next = LOAD;
          start_load = 1'b1;
        end
      end
      LOAD: begin
        take_byte = ioctl_wr;
        if (act_fall) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (byte_count == 17'(TOTAL_BYTES) && !ovf && !ooo) begin
          state_next = DONE;
        end else begin
          state_next = ERROR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status flags are registered from state_next so they line up with the
  // state register rather than trailing it by a cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      act_q      <= 1'b0;
      rom_we     <= '0;
      rom_addr   <= '0;
      rom_data   <= '0;
      core_hold  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      byte_count <= '0;
      checksum   <= '0;
      ovf        <= 1'b0;
      ooo        <= 1'b0;
    end else begin
      act_q      <= act;
      rom_we     <= '0;
      core_hold  <= (state_next != DONE);
      load_done  <= (state_next == DONE);
      load_error <= (state_next == ERROR);
      if (start_load) begin
        byte_count <= '0;
        checksum   <= '0;
        ovf        <= 1'b0;
        ooo        <= 1'b0;
      end
      if (take_byte) begin
        if (addr_ovf) begin
          ovf <= 1'b1;
        end else begin
          if (ioctl_addr != 25'(byte_count)) begin
            ooo <= 1'b1;
          end
          rom_we     <= dec_region;
          rom_addr   <= dec_local;
          rom_data   <= ioctl_dout;
          byte_count <= byte_count + 17'd1;
          checksum   <= checksum + {8'h00, ioctl_dout};
        end
      end
    end
  end

endmodule

// File: tb/tb_zaxxon_rom_loader.sv
// tb_zaxxon_rom_loader
// Two loader instances share one stimulus stream: u_full uses the real image
// length, u_small a short one so complete images fit in a short run. A
// transaction-level model per instance predicts every cycle's outputs.
module tb_zaxxon_rom_loader;

  localparam int unsigned SIM_TOTAL = 32'h900;
  localparam int PH_IDLE  = 0;
  localparam int PH_LOAD  = 1;
  localparam int PH_JUDGE = 2;

  logic        clk_sys;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic [5:0]  rom_we     [2];
  logic [15:0] rom_addr   [2];
  logic [7:0]  rom_data   [2];
  logic        core_hold  [2];
  logic        load_done  [2];
  logic        load_error [2];
  logic [16:0] byte_count [2];
  logic [15:0] checksum   [2];

  int assert_count = 0;
  int fail_count   = 0;
  bit check_en     = 0;

  int unsigned m_total [2] = '{32'h1B200, SIM_TOTAL};
  int          m_phase [2];
  int unsigned m_count [2];
  int unsigned m_sum   [2];
  bit          m_bad   [2];
  bit          m_done  [2];
  bit          m_err   [2];
  bit          m_prev  [2];
  logic [5:0]  exp_we  [2];
  logic [15:0] exp_addr[2];
  logic [7:0]  exp_data[2];

  int unsigned rbase [7] = '{32'h0, 32'h6000, 32'h7000, 32'hD000, 32'h13000, 32'h1B000, 32'h1B200};

  logic [24:0] bnd_addr [5] = '{25'h05FFF, 25'h06000, 25'h1AFFF, 25'h1B000, 25'h1B1FF};
  logic [5:0]  bnd_we   [5] = '{6'h01, 6'h02, 6'h10, 6'h20, 6'h20};
  logic [15:0] bnd_loc  [5] = '{16'h5FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h01FF};

  zaxxon_rom_loader u_full (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .rom_we(rom_we[0]), .rom_addr(rom_addr[0]),
    .rom_data(rom_data[0]), .core_hold(core_hold[0]), .load_done(load_done[0]),
    .load_error(load_error[0]), .byte_count(byte_count[0]), .checksum(checksum[0])
  );

  zaxxon_rom_loader #(.TOTAL_BYTES(SIM_TOTAL)) u_small (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .rom_we(rom_we[1]), .rom_addr(rom_addr[1]),
    .rom_data(rom_data[1]), .core_hold(core_hold[1]), .load_done(load_done[1]),
    .load_error(load_error[1]), .byte_count(byte_count[1]), .checksum(checksum[1])
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
    end
  endtask

  function automatic int regionOf(input int unsigned a);
    for (int i = 0; i < 6; i++) begin
      if (a < rbase[i+1]) return i;
    end
    return 0;
  endfunction

  // Advance the model of instance k by one clock using the inputs just sampled.
  task automatic modelStep(input int k);
    bit act;
    int r;
    act = ioctl_download && (ioctl_index == 8'd0);
    exp_we[k] = '0;
    if (reset) begin
      m_phase[k] = PH_IDLE;
      m_count[k] = 0;
      m_sum[k]   = 0;
      m_bad[k]   = 0;
      m_done[k]  = 0;
      m_err[k]   = 0;
      m_prev[k]  = 0;
      return;
    end
    case (m_phase[k])
      PH_LOAD: begin
        if (ioctl_wr) begin
          if (int'(ioctl_addr) >= int'(m_total[k])) begin
            m_bad[k] = 1;
          end else begin
            if (int'(ioctl_addr) != int'(m_count[k])) m_bad[k] = 1;
            r = regionOf(int'(ioctl_addr));
            exp_we[k]   = 6'(1 << r);
            exp_addr[k] = 16'(int'(ioctl_addr) - int'(rbase[r]));
            exp_data[k] = ioctl_dout;
            m_count[k]  = m_count[k] + 1;
            m_sum[k]    = (m_sum[k] + ioctl_dout) & 32'hFFFF;
          end
        end
        if (!act && m_prev[k]) m_phase[k] = PH_JUDGE;
      end
      PH_JUDGE: begin
        if (m_count[k] == m_total[k] && !m_bad[k]) m_done[k] = 1;
        else m_err[k] = 1;
        m_phase[k] = PH_IDLE;
      end
      default: begin
        if (act && !m_prev[k]) begin
          m_phase[k] = PH_LOAD;
          m_count[k] = 0;
          m_sum[k]   = 0;
          m_bad[k]   = 0;
          m_done[k]  = 0;
          m_err[k]   = 0;
        end
      end
    endcase
    m_prev[k] = act;
  endtask

  task automatic applyStimulus(input bit rst, input bit dl, input logic [7:0] idx,
                               input bit wr, input logic [24:0] a, input logic [7:0] d);
    reset          = rst;
    ioctl_download = dl;
    ioctl_index    = idx;
    ioctl_wr       = wr;
    ioctl_addr     = a;
    ioctl_dout     = d;
    @(posedge clk_sys);
    #1;
    for (int k = 0; k < 2; k++) modelStep(k);
  endtask

  task automatic writeByte(input logic [24:0] a, input logic [7:0] d, input bit fall);
    if ($urandom_range(0, 3) == 0) applyStimulus(0, 1, 8'd0, 0, '0, '0);
    applyStimulus(0, !fall, 8'd0, 1, a, d);
  endtask

  task automatic loadImage(input int n, input bit rnd, input bit fall_last, input int skip);
    bit last;
    applyStimulus(0, 1, 8'd0, 0, '0, '0);
    for (int a = 0; a < n; a++) begin
      if (a == skip) continue;
      last = (a == n - 1) && (skip < 0) && fall_last;
      writeByte(25'(a), rnd ? 8'($urandom) : 8'(a), last);
    end
    if (skip >= 0) writeByte(25'(skip), 8'($urandom), fall_last);
  endtask

  task automatic endLoad();
    applyStimulus(0, 0, 8'd0, 0, '0, '0);
    applyStimulus(0, 0, 8'd0, 0, '0, '0);
    applyStimulus(0, 0, 8'd0, 0, '0, '0);
  endtask

  // Every cycle, both instances are compared with their models.
  always @(negedge clk_sys) begin
    if (check_en) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("rom_we[%0d]", k), 32'(rom_we[k]), 32'(exp_we[k]));
        if (exp_we[k] != 0) begin
          checkOutput($sformatf("rom_addr[%0d]", k), 32'(rom_addr[k]), 32'(exp_addr[k]));
          checkOutput($sformatf("rom_data[%0d]", k), 32'(rom_data[k]), 32'(exp_data[k]));
        end
        checkOutput($sformatf("byte_count[%0d]", k), 32'(byte_count[k]), m_count[k]);
        checkOutput($sformatf("checksum[%0d]", k), 32'(checksum[k]), m_sum[k]);
        checkOutput($sformatf("core_hold[%0d]", k), 32'(core_hold[k]), 32'(!m_done[k]));
        checkOutput($sformatf("load_done[%0d]", k), 32'(load_done[k]), 32'(m_done[k]));
        checkOutput($sformatf("load_error[%0d]", k), 32'(load_error[k]), 32'(m_err[k]));
      end
    end
  end

  initial begin
    applyStimulus(1, 0, 8'd0, 0, '0, '0);
    applyStimulus(1, 0, 8'd0, 0, '0, '0);
    check_en = 1;
    checkOutput("rst_we", 32'(rom_we[0]), 32'h0);
    checkOutput("rst_hold", 32'(core_hold[0]), 32'h1);
    checkOutput("rst_count", 32'(byte_count[0]), 32'h0);
    applyStimulus(0, 0, 8'd0, 0, '0, '0);

    $display("[TB] index 254 download while idle");
    applyStimulus(0, 1, 8'd254, 0, '0, '0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 8'd254, 1, 25'(i), 8'($urandom));
    checkOutput("idx254_we", 32'(rom_we[0]), 32'h0);
    checkOutput("idx254_count", 32'(byte_count[0]), 32'h0);
    applyStimulus(0, 0, 8'd254, 0, '0, '0);
    applyStimulus(0, 0, 8'd0, 0, '0, '0);
    checkOutput("idx254_hold", 32'(core_hold[0]), 32'h1);
    checkOutput("idx254_err", 32'(load_error[0]), 32'h0);

    $display("[TB] region boundaries");
    applyStimulus(0, 1, 8'd0, 0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 8'd0, 0, '0, '0);
      applyStimulus(0, 1, 8'd0, 1, bnd_addr[i], 8'($urandom));
      checkOutput($sformatf("bnd_we_%0h", bnd_addr[i]), 32'(rom_we[0]), 32'(bnd_we[i]));
      checkOutput($sformatf("bnd_addr_%0h", bnd_addr[i]), 32'(rom_addr[0]), 32'(bnd_loc[i]));
    end
    endLoad();
    checkOutput("bnd_err", 32'(load_error[0]), 32'h1);

    $display("[TB] full image");
    loadImage(int'(SIM_TOTAL), 0, 1, -1);
    endLoad();
    checkOutput("full_done", 32'(load_done[1]), 32'h1);
    checkOutput("full_hold", 32'(core_hold[1]), 32'h0);
    checkOutput("full_count", 32'(byte_count[1]), 32'h900);
    checkOutput("full_sum", 32'(checksum[1]), 32'h7B80);
    checkOutput("full_big_err", 32'(load_error[0]), 32'h1);

    $display("[TB] short image");
    loadImage(32'h700, 1, 0, -1);
    endLoad();
    checkOutput("short_err", 32'(load_error[1]), 32'h1);
    checkOutput("short_hold", 32'(core_hold[1]), 32'h1);
    checkOutput("short_count", 32'(byte_count[1]), 32'h700);

    $display("[TB] overflow byte");
    loadImage(int'(SIM_TOTAL), 1, 0, -1);
    applyStimulus(0, 1, 8'd0, 1, 25'(SIM_TOTAL), 8'h5A);
    checkOutput("ovf_we", 32'(rom_we[1]), 32'h0);
    endLoad();
    checkOutput("ovf_count", 32'(byte_count[1]), 32'h900);
    checkOutput("ovf_err", 32'(load_error[1]), 32'h1);

    $display("[TB] out-of-order image");
    loadImage(int'(SIM_TOTAL), 1, 1, 32'h100);
    endLoad();
    checkOutput("ooo_count", 32'(byte_count[1]), 32'h900);
    checkOutput("ooo_err", 32'(load_error[1]), 32'h1);

    $display("[TB] reset mid-load");
    loadImage(32'h300, 1, 0, -1);
    applyStimulus(1, 0, 8'd0, 0, '0, '0);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("mid_we%0d", k), 32'(rom_we[k]), 32'h0);
      checkOutput($sformatf("mid_addr%0d", k), 32'(rom_addr[k]), 32'h0);
      checkOutput($sformatf("mid_data%0d", k), 32'(rom_data[k]), 32'h0);
      checkOutput($sformatf("mid_hold%0d", k), 32'(core_hold[k]), 32'h1);
      checkOutput($sformatf("mid_count%0d", k), 32'(byte_count[k]), 32'h0);
      checkOutput($sformatf("mid_sum%0d", k), 32'(checksum[k]), 32'h0);
      checkOutput($sformatf("mid_done%0d", k), 32'(load_done[k]), 32'h0);
      checkOutput($sformatf("mid_err%0d", k), 32'(load_error[k]), 32'h0);
    end
    applyStimulus(0, 0, 8'd0, 0, '0, '0);
    loadImage(int'(SIM_TOTAL), 0, 1, -1);
    endLoad();
    checkOutput("after_rst_done", 32'(load_done[1]), 32'h1);
    checkOutput("after_rst_sum", 32'(checksum[1]), 32'h7B80);

    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
